// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: NDIG-digit code entry, failed-attempt lockout,
// atomic code change and a blinking active digit on a 5-bit-per-position display bus.
module combo_lock_ctrl #(
   parameter int NDIG        = 4,
   parameter int DW          = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1000,
   parameter int BLINK_HALF  = 50
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ent,
   input  logic                            clr,
   input  logic                            change,
   input  logic [DW-1:0]                   sw,
   output logic [2:0]                      state,
   output logic                            unlocked,
   output logic                            alarm,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
   output logic [5*NDIG-1:0]               disp
);

   localparam int IW = $clog2(NDIG);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [4:0] C_BLANK = 5'h0A;
   localparam logic [4:0] C_DASH  = 5'h11;
   localparam logic [19:0] WORD_CLSD = {5'h0F, 5'h0D, 5'h13, 5'h14};
   localparam logic [19:0] WORD_OPEN = {5'h00, 5'h12, 5'h0E, 5'h0C};

   typedef enum logic [2:0] {
      S_LOCKED   = 3'd0,
      S_ENTRY    = 3'd1,
      S_CHECK    = 3'd2,
      S_OPEN     = 3'd3,
      S_NEWENTRY = 3'd4,
      S_LOCKOUT  = 3'd5
   } state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [NDIG-1:0][DW-1:0]    inbuf_q, inbuf_d;
   logic [NDIG-1:0][DW-1:0]    newbuf_q, newbuf_d;
   logic [NDIG-1:0][DW-1:0]    code_q, code_d;
   logic [FW-1:0]              fail_cnt_q, fail_cnt_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
   logic                       phase_q, phase_d;
   logic                       unlocked_q, unlocked_d;
   logic                       alarm_q, alarm_d;
   logic [NDIG-1:0][4:0]       disp_q, disp_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOCKED;
         idx_q       <= '0;
         inbuf_q     <= '0;
         newbuf_q    <= '0;
         code_q      <= '0;
         fail_cnt_q  <= '0;
         timer_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         unlocked_q  <= 1'b0;
         alarm_q     <= 1'b0;
         disp_q      <= {NDIG{C_BLANK}};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         inbuf_q     <= inbuf_d;
         newbuf_q    <= newbuf_d;
         code_q      <= code_d;
         fail_cnt_q  <= fail_cnt_d;
         timer_q     <= timer_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         unlocked_q  <= unlocked_d;
         alarm_q     <= alarm_d;
         disp_q      <= disp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      inbuf_d    = inbuf_q;
      newbuf_d   = newbuf_q;
      code_d     = code_q;
      fail_cnt_d = fail_cnt_q;
      timer_d    = timer_q;
      case (state_q)
         S_LOCKED: begin
            if (ent) begin
               state_d = S_ENTRY;
               idx_d   = '0;
               inbuf_d = '0;
            end
         end
         S_ENTRY: begin
            if (clr) begin
               idx_d   = '0;
               inbuf_d = '0;
            end else if (ent) begin
               inbuf_d[idx_q] = sw;
               if (idx_q == IW'(NDIG - 1)) state_d = S_CHECK;
               else                        idx_d   = idx_q + IW'(1);
            end
         end
         S_CHECK: begin
            if (inbuf_q == code_q) begin
               state_d    = S_OPEN;
               fail_cnt_d = '0;
            end else begin
               fail_cnt_d = fail_cnt_q + FW'(1);
               if (fail_cnt_d == FW'(MAX_FAIL)) begin
                  state_d = S_LOCKOUT;
                  timer_d = TW'(LOCKOUT_CYC - 1);
               end else begin
                  state_d = S_LOCKED;
               end
            end
         end
         S_OPEN: begin
            if (change) begin
               state_d  = S_NEWENTRY;
               idx_d    = '0;
               newbuf_d = '0;
            end else if (ent) begin
               state_d = S_LOCKED;
            end
         end
         S_NEWENTRY: begin
            if (clr) begin
               idx_d    = '0;
               newbuf_d = '0;
            end else if (ent) begin
               newbuf_d[idx_q] = sw;
               // The code register only ever sees a complete new code.
               if (idx_q == IW'(NDIG - 1)) begin
                  code_d  = newbuf_d;
                  state_d = S_LOCKED;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_LOCKOUT: begin
            if (timer_q == '0) begin
               state_d    = S_LOCKED;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_LOCKED;
      endcase
   end

   // The blink restarts in the visible phase whenever the cursor or state moves.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if ((state_d != state_q) || (idx_d != idx_q)) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // Element NDIG-1 of disp_d is the leftmost position.
   always_comb begin
      logic [4:0] seg;
      seg        = C_BLANK;
      unlocked_d = (state_q == S_OPEN);
      alarm_d    = (state_q == S_LOCKOUT);
      disp_d     = {NDIG{C_BLANK}};
      case (state_q)
         S_LOCKED: disp_d[3:0] = WORD_CLSD;
         S_OPEN:   disp_d[3:0] = WORD_OPEN;
         S_CHECK:  disp_d = disp_q;
         S_LOCKOUT: disp_d = {NDIG{C_DASH}};
         S_ENTRY, S_NEWENTRY: begin
            for (int p = 0; p < NDIG; p++) begin
               if (p < int'(idx_q))
                  seg = (state_q == S_NEWENTRY) ? 5'(newbuf_q[IW'(p)]) : C_DASH;
               else if (p == int'(idx_q))
                  seg = phase_q ? 5'(sw) : C_BLANK;
               else
                  seg = C_BLANK;
               disp_d[IW'(NDIG - 1 - p)] = seg;
            end
         end
         default: disp_d = {NDIG{C_BLANK}};
      endcase
   end

   assign state    = state_q;
   assign unlocked = unlocked_q;
   assign alarm    = alarm_q;
   assign fail_cnt = fail_cnt_q;
   assign disp     = disp_q;

endmodule
